// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: opcode encodings,
// ALU-class match and FSM state encoding.
package pc_seq_pkg;

  localparam logic [3:0] OP_LDI  = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b1001;
  localparam logic [3:0] OP_JZ   = 4'b1010;
  localparam logic [3:0] OP_JNZ  = 4'b1011;
  localparam logic [3:0] OP_CALL = 4'b1100;
  localparam logic [3:0] OP_RET  = 4'b1101;
  localparam logic [3:0] OP_RETI = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // ALU-class opcodes are exactly those with bit 3 clear
  localparam logic [5:0] ALU_MASK = 6'b001000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  function automatic logic is_alu(input logic [5:0] op);
    return (op & ALU_MASK) == 6'b000000;
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Decoder <-> sequencer signal bundle; master is the fetch/decode side,
// slave is the sequencer.
interface pc_seq_if #(parameter int AW = 10) ();
  logic [5:0]    opcode;
  logic [AW-1:0] addr;
  logic          z;
  logic          irq;
  logic          start;
  logic [AW-1:0] pc;
  logic          exec;
  logic          irq_ack;
  logic          halted;
  logic          stack_err;

  modport master (
    output opcode, addr, z, irq, start,
    input  pc, exec, irq_ack, halted, stack_err
  );

  modport slave (
    input  opcode, addr, z, irq, start,
    output pc, exec, irq_ack, halted, stack_err
  );
endinterface

// File: rtl/pc_seq_ret_stack.sv
// Hardware return-address LIFO; top of stack is visible combinationally.
// The caller guarantees push/pop never coincide and never over/underflow.
module ret_stack #(
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int SPW = $clog2(DEPTH) + 1;

  logic [AW-1:0]  r_mem [DEPTH];
  logic [SPW-1:0] r_sp;
  logic [SPW-1:0] w_sp_m1;

  assign w_sp_m1 = r_sp - SPW'(1);
  assign dout    = r_mem[w_sp_m1[SPW-2:0]];
  assign full    = (r_sp == SPW'(DEPTH));
  assign empty   = (r_sp == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_sp <= '0;
    else if (push) r_sp <= r_sp + SPW'(1);
    else if (pop)  r_sp <= w_sp_m1;
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_sp[SPW-2:0]] <= din;
  end
endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: next-pc selection, call/return stack, halt/resume
// and a single-level maskable interrupt. ERR is terminal until reset.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int            AW      = 10,
  parameter int            DEPTH   = 4,
  parameter logic [AW-1:0] IRQ_VEC = AW'(1)
) (
  input logic   clk,
  input logic   reset,
  pc_seq_if.slave bus
);
  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic          r_ie;
  logic          r_stack_err;

  state_t        w_state_nxt;
  logic [AW-1:0] w_pc_nxt;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_din;
  logic [AW-1:0] w_dout;
  logic          w_ie_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_err;
  logic          w_take_irq;

  assign w_pc_inc   = r_pc + AW'(1);
  assign w_take_irq = bus.irq && r_ie && (r_state != ST_ERR);
  assign w_err      = (w_push && w_full) || (w_pop && w_empty);

  ret_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (w_push && !w_err),
    .pop   (w_pop && !w_err),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_pc_nxt    = r_pc;
    w_state_nxt = r_state;
    w_ie_nxt    = r_ie;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_din       = w_pc_inc;
    if (w_take_irq) begin
      // RUN re-executes the interrupted instruction; HALT resumes after it
      w_push      = 1'b1;
      w_din       = (r_state == ST_HALT) ? w_pc_inc : r_pc;
      w_pc_nxt    = IRQ_VEC;
      w_ie_nxt    = 1'b0;
      w_state_nxt = ST_RUN;
    end else if (r_state == ST_HALT) begin
      if (bus.start) begin
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = ST_RUN;
      end
    end else if (r_state == ST_RUN) begin
      if (is_alu(bus.opcode)) begin
        w_pc_nxt = w_pc_inc;
      end else begin
        case (bus.opcode[3:0])
          OP_LDI:  w_pc_nxt = w_pc_inc;
          OP_J:    w_pc_nxt = bus.addr;
          OP_JZ:   w_pc_nxt = bus.z ? bus.addr : w_pc_inc;
          OP_JNZ:  w_pc_nxt = bus.z ? w_pc_inc : bus.addr;
          OP_CALL: begin
            w_push   = 1'b1;
            w_pc_nxt = bus.addr;
          end
          OP_RET: begin
            w_pop    = 1'b1;
            w_pc_nxt = w_dout;
          end
          OP_RETI: begin
            w_pop    = 1'b1;
            w_pc_nxt = w_dout;
            w_ie_nxt = 1'b1;
          end
          OP_HALT: w_state_nxt = ST_HALT;
          default: w_pc_nxt = r_pc;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= '0;
      r_state     <= ST_RUN;
      r_ie        <= 1'b1;
      r_stack_err <= 1'b0;
    end else if (w_err) begin
      r_state     <= ST_ERR;
      r_stack_err <= 1'b1;
    end else begin
      r_pc    <= w_pc_nxt;
      r_state <= w_state_nxt;
      r_ie    <= w_ie_nxt;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.exec      = (r_state == ST_RUN) && !w_take_irq;
  assign bus.irq_ack   = w_take_irq;
  assign bus.halted    = (r_state == ST_HALT);
  assign bus.stack_err = r_stack_err;
endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: directed scenarios plus randomized episodes, all checked
// against a queue-based behavioural model of the sequencer.
module tb_pc_seq;
  localparam int AW      = 10;
  localparam int DEPTH   = 4;
  localparam int IRQ_VEC = 1;
  localparam int MODV    = 1 << AW;

  localparam logic [5:0] ALU  = 6'b000001;
  localparam logic [5:0] J    = 6'b001001;
  localparam logic [5:0] JZ   = 6'b001010;
  localparam logic [5:0] JNZ  = 6'b001011;
  localparam logic [5:0] CALL = 6'b001100;
  localparam logic [5:0] RET  = 6'b001101;
  localparam logic [5:0] RETI = 6'b001110;
  localparam logic [5:0] HALT = 6'b001111;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pc_seq_if #(.AW(AW)) bus ();
  pc_seq_if #(.AW(4))  bus4 ();

  pc_seq #(.AW(AW), .DEPTH(DEPTH), .IRQ_VEC(AW'(IRQ_VEC))) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  pc_seq #(.AW(4), .DEPTH(DEPTH), .IRQ_VEC(4'd1)) u_small (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model
  int m_pc;
  bit m_ie, m_halted, m_err;
  int m_stk[$];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ie = 1; m_halted = 0; m_err = 0;
    m_stk.delete();
  endtask

  task automatic model_update(input logic [5:0] op, input int a, input bit zz,
                              input bit take, input bit ss);
    int inc;
    inc = (m_pc + 1) % MODV;
    if (take) begin
      if (m_stk.size() == DEPTH) m_err = 1;
      else begin
        m_stk.push_back(m_halted ? inc : m_pc);
        m_pc = IRQ_VEC; m_ie = 0; m_halted = 0;
      end
    end else if (m_err) begin
      m_err = 1;
    end else if (m_halted) begin
      if (ss) begin m_pc = inc; m_halted = 0; end
    end else if (!op[3] || op[2:0] == 3'd0) begin
      m_pc = inc;
    end else begin
      case (op[2:0])
        3'd1: m_pc = a;
        3'd2: m_pc = zz ? a : inc;
        3'd3: m_pc = zz ? inc : a;
        3'd4: if (m_stk.size() == DEPTH) m_err = 1;
              else begin m_stk.push_back(inc); m_pc = a; end
        3'd5: if (m_stk.size() == 0) m_err = 1;
              else m_pc = m_stk.pop_back();
        3'd6: if (m_stk.size() == 0) m_err = 1;
              else begin m_pc = m_stk.pop_back(); m_ie = 1; end
        default: m_halted = 1;
      endcase
    end
  endtask

  // Called at a negedge: drive, check this cycle's outputs, clock, update model.
  task automatic step(input logic [5:0] op, input int a, input bit zz,
                      input bit ii, input bit ss);
    bit take;
    bus.opcode = op; bus.addr = AW'(a); bus.z = zz; bus.irq = ii; bus.start = ss;
    #1;
    take = ii && m_ie && !m_err;
    check("pc",        bus.pc,        m_pc);
    check("exec",      bus.exec,      !m_halted && !m_err && !take);
    check("irq_ack",   bus.irq_ack,   take);
    check("halted",    bus.halted,    m_halted);
    check("stack_err", bus.stack_err, m_err);
    @(posedge clk);
    model_update(op, a, zz, take, ss);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.opcode = ALU; bus.addr = '0; bus.z = 0; bus.irq = 0; bus.start = 0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic alu_n(input int n);
    for (int i = 0; i < n; i++) step(ALU, 0, 0, 0, 0);
  endtask

  initial begin
    bus4.opcode = ALU; bus4.addr = '0; bus4.z = 0; bus4.irq = 0; bus4.start = 0;
  end

  initial begin
    logic [5:0] op;
    int r;

    // sequential run
    do_reset();
    alu_n(5);
    check("alu_run_pc", bus.pc, 5);

    // conditional jumps
    do_reset();
    alu_n(3);
    step(JZ, 20, 1, 0, 0);
    check("jz_taken", bus.pc, 20);
    step(JNZ, 40, 1, 0, 0);
    check("jnz_not_taken", bus.pc, 21);

    // nested calls and returns
    do_reset();
    alu_n(2);
    step(CALL, 10, 0, 0, 0); alu_n(2);
    step(CALL, 30, 0, 0, 0); alu_n(2);
    step(CALL, 50, 0, 0, 0); alu_n(1);
    check("call_depth3_pc", bus.pc, 51);
    step(RET, 0, 0, 0, 0);
    check("ret1", bus.pc, 33);
    step(RET, 0, 0, 0, 0);
    check("ret2", bus.pc, 13);
    step(RET, 0, 0, 0, 0);
    check("ret3", bus.pc, 3);

    // overflow on fifth push
    do_reset();
    for (int i = 0; i < 5; i++) step(CALL, 100, 0, 0, 0);
    check("ovf_err", bus.stack_err, 1);
    check("ovf_pc", bus.pc, 100);
    check("ovf_exec", bus.exec, 0);
    step(J, 7, 0, 1, 1);
    step(RET, 0, 0, 1, 0);

    // underflow
    do_reset();
    alu_n(1);
    step(RET, 0, 0, 0, 0);
    check("udf_err", bus.stack_err, 1);

    // interrupt in RUN, held irq, RETI and re-take
    do_reset();
    alu_n(7);
    step(ALU, 0, 0, 1, 0);
    check("irq_vec", bus.pc, IRQ_VEC);
    step(ALU, 0, 0, 1, 0);
    step(ALU, 0, 0, 1, 0);
    step(RETI, 0, 0, 1, 0);
    check("reti_pc", bus.pc, 7);
    step(ALU, 0, 0, 1, 0);
    check("irq_retake", bus.pc, IRQ_VEC);

    // halt / start / interrupt from halt
    do_reset();
    alu_n(9);
    step(HALT, 0, 0, 0, 0);
    check("halt_flag", bus.halted, 1);
    step(ALU, 0, 0, 0, 0);
    step(ALU, 0, 0, 0, 0);
    step(ALU, 0, 0, 0, 1);
    check("start_pc", bus.pc, 10);
    step(HALT, 0, 0, 0, 0);
    step(ALU, 0, 0, 1, 0);
    check("halt_irq_pc", bus.pc, IRQ_VEC);
    step(RETI, 0, 0, 0, 0);
    check("halt_reti_pc", bus.pc, 11);

    // wrap at all-ones (both widths)
    do_reset();
    step(J, MODV - 1, 0, 0, 0);
    step(ALU, 0, 0, 0, 0);
    check("wrap10", bus.pc, 0);
    do_reset();
    for (int i = 0; i < 18; i++) begin
      #1 check("wrap4", bus4.pc, i % 16);
      step(ALU, 0, 0, 0, 0);
    end

    // asynchronous reset mid-call sequence
    do_reset();
    alu_n(2);
    step(CALL, 10, 0, 0, 0);
    step(CALL, 30, 0, 0, 0);
    bus.opcode = HALT;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_pc", bus.pc, 0);
    check("arst_halted", bus.halted, 0);
    check("arst_err", bus.stack_err, 0);
    check("arst_ack", bus.irq_ack, 0);
    check("arst_exec", bus.exec, 1);
    model_reset();
    @(negedge clk);
    bus.opcode = ALU;
    reset = 1'b1;
    alu_n(2);

    // randomized episodes
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      for (int c = 0; c < 25; c++) begin
        r = $urandom_range(0, 99);
        if (r < 35)      op = 6'($urandom) & 6'h37;
        else if (r < 42) op = {2'($urandom), 4'b1000};
        else             op = {2'($urandom), 1'b1, 3'($urandom_range(1, 7))};
        step(op, int'($urandom_range(0, MODV - 1)), 1'($urandom),
             $urandom_range(0, 9) == 0, 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
